// File: rtl/jbusctl.sv
// -----------------------------------------------------------------------------
// jbusctl - bus transfer sequencer for a bank of 8-bit bus registers.
//
// Moves one byte per accepted request from a source register (or from an
// immediate byte driven onto the shared bus) into a destination register.
// Every transfer runs the fixed sequence ENA -> SET -> HOLD:
//   ENA  : source enabled onto the bus (or immediate driven), no set strobe
//   SET  : source still enabled, destination set strobe high
//   HOLD : source still enabled, set strobe released, done pulses
// Enabling the source one cycle before the set strobe, and keeping it one
// cycle after, guarantees the destination latches a settled bus value.
//
// Configuration macro: JBUSCTL_PIPE_EN
//   defined   : a new request may be accepted in HOLD (3 cycles/transfer)
//   undefined : requests are accepted only in IDLE (4 cycles/transfer)
//
// Ports:
//   clk        in     system clock, rising edge
//   reset      in     synchronous active-high reset
//   req_valid  in     transfer request present
//   req_ready  out    request can be accepted this cycle
//   req_src    in     source register index (ignored for immediates)
//   req_dst    in     destination register index
//   req_imm    in     1: source is imm_data, 0: source is register req_src
//   imm_data   in     immediate byte, captured at accept
//   we_bus     out    one-hot register enable strobes
//   ws_bus     out    one-hot register set strobes
//   bus        inout  shared register bus, driven only for immediates
//   busy       out    transfer in flight
//   done       out    one-cycle transfer-complete pulse
// -----------------------------------------------------------------------------
module jbusctl #(
    parameter int N  = 2,
    parameter int NR = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [N-1:0]  req_src,
    input  logic [N-1:0]  req_dst,
    input  logic          req_imm,
    input  logic [7:0]    imm_data,
    output logic [NR-1:0] we_bus,
    output logic [NR-1:0] ws_bus,
    inout  wire  [7:0]    bus,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENA  = 2'd1,
        ST_SET  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] src_q, src_d;
    logic [N-1:0] dst_q, dst_d;
    logic [7:0]   imm_q, imm_d;
    logic         imm_sel_q, imm_sel_d;
    logic         nop_q, nop_d;   // register self-move: runs the sequence with no strobes

    logic         accept_s;
    logic         bus_oe_s;

    assign accept_s = req_valid && req_ready;

    // The bus is only ever driven by this block while an immediate is in flight.
    assign bus = bus_oe_s ? imm_q : 8'bzzzz_zzzz;

    // State and captured-request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            imm_q     <= 8'h00;
            imm_sel_q <= 1'b0;
            nop_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            imm_q     <= imm_d;
            imm_sel_q <= imm_sel_d;
            nop_q     <= nop_d;
        end
    end

    // Next-state logic and request capture.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        imm_d     = imm_q;
        imm_sel_d = imm_sel_q;
        nop_d     = nop_q;

        if (accept_s) begin
            src_d     = req_src;
            dst_d     = req_dst;
            imm_d     = imm_data;
            imm_sel_d = req_imm;
            nop_d     = !req_imm && (req_src == req_dst);
        end else begin
            src_d     = src_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_ENA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ENA: begin
                // A self-move skips SET so no set strobe is ever issued.
                if (nop_q) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_SET;
                end
            end
            ST_SET: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (accept_s) begin
                    state_d = ST_ENA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state and captured indices only.
    always_comb begin
        we_bus    = '0;
        ws_bus    = '0;
        bus_oe_s  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        req_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
            end
            ST_ENA: begin
                busy = 1'b1;
                if (imm_sel_q) begin
                    bus_oe_s = 1'b1;
                end else if (!nop_q) begin
                    we_bus = NR'(1) << src_q;
                end else begin
                    we_bus = '0;
                end
            end
            ST_SET: begin
                busy = 1'b1;
                if (imm_sel_q) begin
                    bus_oe_s = 1'b1;
                end else begin
                    we_bus = NR'(1) << src_q;
                end
                ws_bus = NR'(1) << dst_q;
            end
            ST_HOLD: begin
                busy = 1'b1;
                done = 1'b1;
`ifdef JBUSCTL_PIPE_EN
                req_ready = 1'b1;
`else
                req_ready = 1'b0;
`endif
                if (imm_sel_q) begin
                    bus_oe_s = 1'b1;
                end else if (!nop_q) begin
                    we_bus = NR'(1) << src_q;
                end else begin
                    we_bus = '0;
                end
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_jbusctl.sv
// -----------------------------------------------------------------------------
// tb_jbusctl - directed self-checking bench for jbusctl.
// The bus net has a pull-up so an undriven bus reads 8'hFF; register
// transfers carry imm_data=8'h5A so a wrongful drive is visible.
// -----------------------------------------------------------------------------
module tb_jbusctl;

    localparam int N  = 2;
    localparam int NR = 4;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [N-1:0]  req_src;
    logic [N-1:0]  req_dst;
    logic          req_imm;
    logic [7:0]    imm_data;
    logic [NR-1:0] we_bus;
    logic [NR-1:0] ws_bus;
    tri1  [7:0]    bus;
    logic          busy;
    logic          done;

    int n_checks;
    int n_fail;

    jbusctl #(.N(N), .NR(NR)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .req_imm   (req_imm),
        .imm_data  (imm_data),
        .we_bus    (we_bus),
        .ws_bus    (ws_bus),
        .bus       (bus),
        .busy      (busy),
        .done      (done)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [N-1:0] s, input logic [N-1:0] d,
                           input logic im, input logic [7:0] dat);
        req_valid = v;
        req_src   = s;
        req_dst   = d;
        req_imm   = im;
        imm_data  = dat;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_we"},    32'(we_bus),    32'h0);
        check_eq({tag, "_ws"},    32'(ws_bus),    32'h0);
        check_eq({tag, "_bus"},   32'(bus),       32'hFF);
        check_eq({tag, "_ready"}, 32'(req_ready), 32'h1);
        check_eq({tag, "_busy"},  32'(busy),      32'h0);
        check_eq({tag, "_done"},  32'(done),      32'h0);
    endtask

`ifdef JBUSCTL_PIPE_EN
    localparam int DROP = 3;
    logic [3:0] exp_we[8]   = '{4'h8, 4'h8, 4'h8, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0};
    logic [3:0] exp_ws[8]   = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0};
    logic       exp_done[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`else
    localparam int DROP = 4;
    logic [3:0] exp_we[8]   = '{4'h8, 4'h8, 4'h8, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0};
    logic [3:0] exp_ws[8]   = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0};
    logic       exp_done[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        set_req(1'b0, 2'd0, 2'd0, 1'b0, 8'h5A);

        // 1. reset for two cycles, then idle
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_idle("rst");

        // 2. register move 1 -> 3
        set_req(1'b1, 2'd1, 2'd3, 1'b0, 8'h5A);
        tick();
        set_req(1'b0, 2'd0, 2'd0, 1'b0, 8'h5A);
        check_eq("mv_ena_we",    32'(we_bus),    32'h2);
        check_eq("mv_ena_ws",    32'(ws_bus),    32'h0);
        check_eq("mv_ena_bus",   32'(bus),       32'hFF);
        check_eq("mv_ena_busy",  32'(busy),      32'h1);
        check_eq("mv_ena_ready", 32'(req_ready), 32'h0);
        tick();
        check_eq("mv_set_we",    32'(we_bus),    32'h2);
        check_eq("mv_set_ws",    32'(ws_bus),    32'h8);
        check_eq("mv_set_done",  32'(done),      32'h0);
        tick();
        check_eq("mv_hold_we",   32'(we_bus),    32'h2);
        check_eq("mv_hold_ws",   32'(ws_bus),    32'h0);
        check_eq("mv_hold_done", 32'(done),      32'h1);
        tick();
        check_idle("mv_end");

        // 3. immediate A5 -> register 2 (src index must be ignored)
        set_req(1'b1, 2'd1, 2'd2, 1'b1, 8'hA5);
        tick();
        set_req(1'b0, 2'd0, 2'd0, 1'b0, 8'h5A);
        check_eq("im_ena_bus",   32'(bus),    32'hA5);
        check_eq("im_ena_we",    32'(we_bus), 32'h0);
        check_eq("im_ena_ws",    32'(ws_bus), 32'h0);
        tick();
        check_eq("im_set_bus",   32'(bus),    32'hA5);
        check_eq("im_set_we",    32'(we_bus), 32'h0);
        check_eq("im_set_ws",    32'(ws_bus), 32'h4);
        tick();
        check_eq("im_hold_bus",  32'(bus),    32'hA5);
        check_eq("im_hold_ws",   32'(ws_bus), 32'h0);
        check_eq("im_hold_done", 32'(done),   32'h1);
        tick();
        check_idle("im_end");

        // 4. self-move 2 -> 2 is a NOP that still completes
        set_req(1'b1, 2'd2, 2'd2, 1'b0, 8'h5A);
        tick();
        set_req(1'b0, 2'd0, 2'd0, 1'b0, 8'h5A);
        check_eq("nop_ena_we",   32'(we_bus), 32'h0);
        check_eq("nop_ena_ws",   32'(ws_bus), 32'h0);
        check_eq("nop_ena_bus",  32'(bus),    32'hFF);
        check_eq("nop_ena_done", 32'(done),   32'h0);
        check_eq("nop_ena_busy", 32'(busy),   32'h1);
        tick();
        check_eq("nop_hold_we",   32'(we_bus), 32'h0);
        check_eq("nop_hold_ws",   32'(ws_bus), 32'h0);
        check_eq("nop_hold_done", 32'(done),   32'h1);
        tick();
        check_idle("nop_end");

        // 5. reset during SET abandons the transfer
        set_req(1'b1, 2'd0, 2'd1, 1'b0, 8'h5A);
        tick();
        set_req(1'b0, 2'd0, 2'd0, 1'b0, 8'h5A);
        tick();
        check_eq("rs_set_ws", 32'(ws_bus), 32'h2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("rs_after");
        tick();
        check_idle("rs_after2");

        // 6. req_valid held for two back-to-back requests
        set_req(1'b1, 2'd3, 2'd0, 1'b0, 8'h5A);
        tick();
        set_req(1'b1, 2'd1, 2'd2, 1'b0, 8'h5A);
        for (int i = 0; i < 8; i++) begin
            if (i == DROP) begin
                set_req(1'b0, 2'd0, 2'd0, 1'b0, 8'h5A);
            end
            check_eq($sformatf("b2b_we_%0d", i),   32'(we_bus), 32'(exp_we[i]));
            check_eq($sformatf("b2b_ws_%0d", i),   32'(ws_bus), 32'(exp_ws[i]));
            check_eq($sformatf("b2b_done_%0d", i), 32'(done),   32'(exp_done[i]));
            check_eq($sformatf("b2b_bus_%0d", i),  32'(bus),    32'hFF);
            tick();
        end
        check_idle("b2b_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
